// File: rtl/sd_spi_pkg.sv
// Shared types and register map for the SD-card SPI master.
// Used by sd_spi_master and sd_spi_edge.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } spi_state_t;

  localparam logic [15:0] CTRL_OFS = 16'd0;
  localparam logic [15:0] DATA_OFS = 16'd1;

  localparam int FAST_BIT = 7;
  localparam int BUSY_BIT = 6;
  localparam int OVR_BIT  = 5;

  localparam logic [7:0] RX_RESET = 8'hFF;

  // Control register readback: {fast, busy, ovr, 0, cs[3:0]}.
  function automatic logic [7:0] ctrl_word(input logic fast, input logic busy,
                                           input logic ovr, input logic [3:0] cs);
    logic [7:0] w;
    w           = 8'h00;
    w[3:0]      = cs;
    w[OVR_BIT]  = ovr;
    w[BUSY_BIT] = busy;
    w[FAST_BIT] = fast;
    return w;
  endfunction

endpackage

// File: rtl/sd_spi_edge.sv
// One-cycle strobe on the falling edge of an active-low bus level.
// A level held low for many cycles yields exactly one strobe.
module sd_spi_edge (
  input  logic clk64,
  input  logic reset,
  input  logic level_n,
  output logic strobe
);

  logic level_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk64 or posedge reset) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= level_n;
  end

  assign strobe = level_q & ~level_n;

endmodule

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 master for the SD card on the CPU bus (control at
// BASE_ADDR, data at BASE_ADDR+1). Define SD_SPI_AUTOREAD_EN for read-triggered transfers.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hF700,
  parameter int          NUM_CS    = 1,
  parameter int          DIV_SLOW  = 80,
  parameter int          DIV_FAST  = 2
) (
  input  logic              clk64,
  input  logic              reset,
  input  logic [15:0]       adr,
  input  logic [7:0]        wdata,
  input  logic              we_n,
  input  logic              oe_n,
  output logic [7:0]        rdata,
  output logic              sel,
  output logic              sd_clk,
  output logic              sd_mosi,
  input  logic              sd_miso,
  output logic [NUM_CS-1:0] sd_cs_n,
  output logic              busy
);

  localparam int          DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int          HALF_W   = $clog2(DIV_MAX + 1);
  localparam logic [15:0] CTRL_ADR = BASE_ADDR + CTRL_OFS;
  localparam logic [15:0] DATA_ADR = BASE_ADDR + DATA_OFS;

  spi_state_t        state;
  logic [7:0]        shift_q;
  logic [7:0]        rx_byte;
  logic [2:0]        bit_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic [HALF_W-1:0] half_reload;
  logic              fast;
  logic              ovr;
  logic [NUM_CS-1:0] cs;

  logic ctrl_hit, data_hit;
  logic wr_stb, ctrl_wr, data_wr;
  logic rd_start, start;
  logic [7:0] start_byte;

  assign ctrl_hit = (adr == CTRL_ADR);
  assign data_hit = (adr == DATA_ADR);
  assign sel      = (ctrl_hit | data_hit) & ~oe_n;

  sd_spi_edge u_we_edge (
    .clk64   (clk64),
    .reset   (reset),
    .level_n (we_n),
    .strobe  (wr_stb)
  );

  assign ctrl_wr = wr_stb & ctrl_hit;
  assign data_wr = wr_stb & data_hit;

`ifdef SD_SPI_AUTOREAD_EN
  logic rd_stb;

  sd_spi_edge u_oe_edge (
    .clk64   (clk64),
    .reset   (reset),
    .level_n (oe_n),
    .strobe  (rd_stb)
  );

  // The read itself returns the old rx byte; the dummy 0xFF shift follows.
  assign rd_start = rd_stb & data_hit & (state == IDLE);
`else
  assign rd_start = 1'b0;
`endif

  assign start       = (state == IDLE) & (data_wr | rd_start);
  assign start_byte  = data_wr ? wdata : 8'hFF;
  assign half_reload = fast ? HALF_W'(DIV_FAST - 1) : HALF_W'(DIV_SLOW - 1);
  assign sd_cs_n     = ~cs;

  always_ff @(posedge clk64 or posedge reset) begin
    if (reset) begin
      cs   <= '0;
      fast <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        cs   <= wdata[NUM_CS-1:0];
        fast <= wdata[FAST_BIT];
      end
      // DONE still counts as busy, so a write landing there is an overrun.
      if (data_wr && state != IDLE) ovr <= 1'b1;
      else if (ctrl_wr && wdata[OVR_BIT]) ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk64 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sd_clk   <= 1'b0;
      sd_mosi  <= 1'b1;
      shift_q  <= 8'hFF;
      rx_byte  <= RX_RESET;
      bit_cnt  <= 3'd0;
      half_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Byte captured here: wdata is only guaranteed on the strobe cycle.
          if (start) begin
            shift_q <= start_byte;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          sd_mosi  <= shift_q[7];
          bit_cnt  <= 3'd0;
          half_cnt <= half_reload;
          state    <= LOW;
        end
        LOW: begin
          if (half_cnt == '0) begin
            sd_clk   <= 1'b1;
            shift_q  <= {shift_q[6:0], sd_miso};
            half_cnt <= half_reload;
            state    <= HIGH;
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        HIGH: begin
          if (half_cnt == '0) begin
            sd_clk   <= 1'b0;
            half_cnt <= half_reload;
            if (bit_cnt == 3'd7) begin
              sd_mosi <= 1'b1;
              state   <= DONE;
            end else begin
              sd_mosi <= shift_q[7];
              bit_cnt <= bit_cnt + 3'd1;
              state   <= LOW;
            end
          end else begin
            half_cnt <= half_cnt - 1'b1;
          end
        end
        DONE: begin
          rx_byte <= shift_q;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: rdata gets a default before the conditional override so no
    // path leaves it unassigned (which would infer a latch).
    rdata = ctrl_word(fast, busy, ovr, 4'(cs));
    if (data_hit) rdata = rx_byte;
  end

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: stimulus queues expected reads and
// transfers, a negedge monitor pops and compares them.
module tb_sd_spi_master;
  import sd_spi_pkg::*;

  localparam logic [15:0] CTRL_ADR  = 16'hF700;
  localparam logic [15:0] DATA_ADR  = 16'hF701;
  localparam int          BUSY_FAST = 34;
  localparam int          BUSY_SLOW = 1282;
  localparam int          SCKH_FAST = 16;
  localparam int          SCKH_SLOW = 640;

  typedef struct {
    logic [7:0] tx;
    int         busy_cycles;
    int         sck_high;
  } xfer_t;

  logic        clk64 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] adr   = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        we_n  = 1'b1;
  logic        oe_n  = 1'b1;
  logic [7:0]  rdata;
  logic        sel;
  logic        sd_clk;
  logic        sd_mosi;
  logic        sd_miso;
  logic [0:0]  sd_cs_n;
  logic        busy;

  sd_spi_master dut (
    .clk64   (clk64),
    .reset   (reset),
    .adr     (adr),
    .wdata   (wdata),
    .we_n    (we_n),
    .oe_n    (oe_n),
    .rdata   (rdata),
    .sel     (sel),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso),
    .sd_cs_n (sd_cs_n),
    .busy    (busy)
  );

  always #5 clk64 = ~clk64;

  xfer_t      xfer_q[$];
  logic [7:0] read_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_xfers  = 0;
  logic       tb_fast  = 1'b0;
  logic [7:0] miso_byte = 8'hFF;
  logic [7:0] miso_sh   = 8'hFF;

  assign sd_miso = miso_sh[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: read scoreboard, MISO slave model and per-transfer checks.
  logic       clk_q = 1'b0;
  logic       busy_q = 1'b0;
  logic [7:0] mosi_acc = 8'h00;
  logic [7:0] exp_rd;
  xfer_t      exp_x;
  int         rises = 0, high_cnt = 0, busy_cnt = 0;

  always @(negedge clk64) begin
    if (sel) begin
      check("read_expected", 32'(read_q.size() != 0), 1);
      if (read_q.size() != 0) begin
        exp_rd = read_q.pop_front();
        check("rdata", 32'(rdata), 32'(exp_rd));
      end
    end
    if (reset) begin
      busy_q = 1'b0;
      clk_q  = 1'b0;
    end else begin
      if (busy && !busy_q) begin
        rises = 0; high_cnt = 0; busy_cnt = 0; mosi_acc = 8'h00;
        miso_sh = miso_byte;
      end
      if (sd_clk && !clk_q) begin
        mosi_acc = {mosi_acc[6:0], sd_mosi};
        rises++;
      end else if (sd_clk) begin
        check("mosi_stable_sck_high", 32'(sd_mosi), 32'(mosi_acc[0]));
      end
      if (!sd_clk && clk_q) miso_sh = {miso_sh[6:0], 1'b1};
      if (sd_clk) high_cnt++;
      if (busy) busy_cnt++;
      if (!busy && busy_q) begin
        n_xfers++;
        check("xfer_expected", 32'(xfer_q.size() != 0), 1);
        if (xfer_q.size() != 0) begin
          exp_x = xfer_q.pop_front();
          check("mosi_byte", 32'(mosi_acc), 32'(exp_x.tx));
          check("sck_rises", 32'(rises), 8);
          check("busy_cycles", 32'(busy_cnt), 32'(exp_x.busy_cycles));
          check("sck_high_cycles", 32'(high_cnt), 32'(exp_x.sck_high));
        end
      end
      busy_q = busy;
      clk_q  = sd_clk;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk64);
    #1;
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    adr = a; wdata = d; we_n = 1'b0;
    cyc(1);
    we_n = 1'b1;
    cyc(1);
    if (a == CTRL_ADR) tb_fast = d[7];
  endtask

  task automatic read_reg(input logic [15:0] a, input logic [7:0] exp);
    read_q.push_back(exp);
    adr = a; oe_n = 1'b0;
    cyc(1);
    oe_n = 1'b1;
    cyc(1);
  endtask

  task automatic expect_xfer(input logic [7:0] tx);
    xfer_t x;
    x.tx          = tx;
    x.busy_cycles = tb_fast ? BUSY_FAST : BUSY_SLOW;
    x.sck_high    = tb_fast ? SCKH_FAST : SCKH_SLOW;
    xfer_q.push_back(x);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      cyc(1);
      n++;
    end
    check("wait_idle_timeout", 32'(busy), 0);
    cyc(2);
  endtask

  // Data reads happen only when rx already equals miso_byte, so an
  // autoread dummy transfer leaves the rx byte unchanged.
  task automatic read_data(input logic [7:0] exp);
`ifdef SD_SPI_AUTOREAD_EN
    expect_xfer(8'hFF);
    read_reg(DATA_ADR, exp);
    wait_idle();
`else
    read_reg(DATA_ADR, exp);
    cyc(2);
    check("read_no_side_effect", 32'(busy), 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers_before;

    #23 reset = 1'b0;
    cyc(2);
    check("reset_cs_n", 32'(sd_cs_n), 1);
    check("reset_sck", 32'(sd_clk), 0);
    check("reset_mosi", 32'(sd_mosi), 1);
    check("reset_busy", 32'(busy), 0);
    read_reg(CTRL_ADR, 8'h00);
    read_data(8'hFF);

    // Fast transfer of A5 with the card answering 3C.
    write_reg(CTRL_ADR, 8'h81);
    check("cs_asserted", 32'(sd_cs_n), 0);
    check("cs_write_sck", 32'(sd_clk), 0);
    check("cs_write_mosi", 32'(sd_mosi), 1);
    read_reg(CTRL_ADR, 8'h81);
    miso_byte = 8'h3C;
    expect_xfer(8'hA5);
    write_reg(DATA_ADR, 8'hA5);
    wait_idle();
    read_data(8'h3C);

    // Slow transfer, with an overrunning write in the middle.
    write_reg(CTRL_ADR, 8'h01);
    read_reg(CTRL_ADR, 8'h01);
    expect_xfer(8'hFF);
    write_reg(DATA_ADR, 8'hFF);
    cyc(10);
    write_reg(DATA_ADR, 8'h77);
    read_reg(CTRL_ADR, 8'h61);
    wait_idle();
    read_reg(CTRL_ADR, 8'h21);
    write_reg(CTRL_ADR, 8'hA1);
    read_reg(CTRL_ADR, 8'h81);
    read_data(8'h3C);

    // Reset during the 4th bit (fast mode: bit 3 low phase is cycles 12..13).
    write_reg(DATA_ADR, 8'hA5);
    cyc(13);
    check("busy_before_reset", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("abort_sck", 32'(sd_clk), 0);
    check("abort_cs_n", 32'(sd_cs_n), 1);
    check("abort_busy", 32'(busy), 0);
    tb_fast = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    miso_byte = 8'hFF;
    read_data(8'hFF);
    read_reg(CTRL_ADR, 8'h00);

    // we_n held low for 200 cycles must give exactly one transfer.
    write_reg(CTRL_ADR, 8'h81);
    miso_byte    = 8'hC3;
    xfers_before = n_xfers;
    expect_xfer(8'h5A);
    adr = DATA_ADR; wdata = 8'h5A; we_n = 1'b0;
    cyc(200);
    we_n = 1'b1;
    cyc(1);
    wait_idle();
    cyc(40);
    check("single_xfer_on_held_we", 32'(n_xfers), 32'(xfers_before + 1));
    read_data(8'hC3);

`ifdef SD_SPI_AUTOREAD_EN
    // Read returns the old byte and clocks out FF; the next read sees 96.
    miso_byte = 8'h96;
    read_data(8'hC3);
    read_data(8'h96);
`endif

    cyc(5);
    check("xfer_queue_empty", 32'(xfer_q.size()), 0);
    check("read_queue_empty", 32'(read_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
